// File: rtl/lab5_mcore_mem_net_endpoint_if.sv
`default_nettype none
// ============================================================================
// Module : lab5_mcore_mem_net_endpoint_if (+ message type package)
// Brief  : Message types and bundled handshake channels for the bank-side
//          memory network endpoint (netreq in, memreq out, memresp in,
//          netresp out, sticky dest error flag).
// Rev    : 1.0  initial release
// ============================================================================

package lab5_mcore_mem_net_endpoint_pkg;

  typedef struct packed {
    logic [1:0] dest;
    logic [1:0] src;
    logic [7:0] opaque;
  } net_hdr_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

interface lab5_mcore_mem_net_endpoint_if;
  import lab5_mcore_mem_net_endpoint_pkg::*;

  logic         netreq_val;
  logic         netreq_rdy;
  net_hdr_t     netreq_msg_hdr;
  mem_req_4B_t  netreq_msg_payload;

  logic         memreq_val;
  logic         memreq_rdy;
  mem_req_4B_t  memreq_msg;

  logic         memresp_val;
  logic         memresp_rdy;
  mem_resp_4B_t memresp_msg;

  logic         netresp_val;
  logic         netresp_rdy;
  net_hdr_t     netresp_msg_hdr;
  mem_resp_4B_t netresp_msg_payload;

  logic         dest_err;

  // Endpoint view
  modport slave (
    input  netreq_val, netreq_msg_hdr, netreq_msg_payload,
    output netreq_rdy,
    output memreq_val, memreq_msg,
    input  memreq_rdy,
    input  memresp_val, memresp_msg,
    output memresp_rdy,
    output netresp_val, netresp_msg_hdr, netresp_msg_payload,
    input  netresp_rdy,
    output dest_err
  );

  // Environment view (network + memory side)
  modport master (
    output netreq_val, netreq_msg_hdr, netreq_msg_payload,
    input  netreq_rdy,
    input  memreq_val, memreq_msg,
    output memreq_rdy,
    output memresp_val, memresp_msg,
    input  memresp_rdy,
    input  netresp_val, netresp_msg_hdr, netresp_msg_payload,
    output netresp_rdy,
    input  dest_err
  );

endinterface

`default_nettype wire

// File: rtl/lab5_mcore_mem_net_endpoint.sv
`default_nettype none
// ============================================================================
// Module : lab5_mcore_mem_net_endpoint
// Brief  : Bank-side network endpoint. Strips request headers, forwards the
//          payload to memory through a one-entry request register, queues
//          memory responses and returns them as packets routed by the top two
//          opaque bits. Credits cap requests in flight at the response queue
//          depth, so the memory response port is never back-pressured.
// Rev    : 1.0  initial release
// ============================================================================

module lab5_mcore_mem_net_endpoint
  import lab5_mcore_mem_net_endpoint_pkg::*;
#(
  parameter int p_num_credits = 2,
  parameter bit p_check_dest  = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       reset,   // active-low, asynchronous
  input  wire logic [1:0] src_id,
  lab5_mcore_mem_net_endpoint_if.slave bus
);

  localparam int CNT_W = $clog2(p_num_credits + 1);
  localparam int PTR_W = (p_num_credits > 1) ? $clog2(p_num_credits) : 1;
  localparam logic [CNT_W-1:0] NUM_CREDITS = CNT_W'(p_num_credits);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(p_num_credits - 1);

  logic             reqreg_valid;
  mem_req_4B_t      reqreg_msg;
  logic [CNT_W-1:0] credits_used;
  logic [CNT_W-1:0] q_count;
  logic [PTR_W-1:0] q_head;
  logic [PTR_W-1:0] q_tail;
  mem_resp_4B_t     q_mem [p_num_credits];
  logic             dest_err_q;

  logic             netreq_fire;
  logic             memreq_fire;
  logic             memresp_fire;
  logic             netresp_fire;
  mem_resp_4B_t     head_msg;
  net_hdr_t         resp_hdr;

  // Source and opaque fields of the incoming header carry no meaning here.
  logic unused_hdr;
  assign unused_hdr = ^{bus.netreq_msg_hdr.src, bus.netreq_msg_hdr.opaque};

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes; ready outputs are forced low while reset is asserted.
  assign bus.netreq_rdy  = reset && (credits_used < NUM_CREDITS)
                                 && (!reqreg_valid || bus.memreq_rdy);
  assign bus.memresp_rdy = reset && (q_count < NUM_CREDITS);

  assign netreq_fire  = bus.netreq_val  && bus.netreq_rdy;
  assign memreq_fire  = reqreg_valid    && bus.memreq_rdy;
  assign memresp_fire = bus.memresp_val && bus.memresp_rdy;
  assign netresp_fire = bus.netresp_val && bus.netresp_rdy;

  assign bus.memreq_val = reqreg_valid;
  assign bus.memreq_msg = reqreg_msg;

  assign head_msg                = q_mem[q_head];
  assign bus.netresp_val         = (q_count != '0);
  assign bus.netresp_msg_payload = head_msg;
  assign bus.netresp_msg_hdr     = resp_hdr;
  assign bus.dest_err            = dest_err_q;

  // Build the response header: route back to the requester named in opaque.
  always_comb begin
    resp_hdr        = '0;
    resp_hdr.dest   = head_msg.opaque[7:6];
    resp_hdr.src    = src_id;
    resp_hdr.opaque = 8'h00;
  end

  // Request register: load on accept, drain when memory takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqreg_valid <= 1'b0;
      reqreg_msg   <= '0;
    end else if (netreq_fire) begin
      reqreg_valid <= 1'b1;
      reqreg_msg   <= bus.netreq_msg_payload;
    end else if (memreq_fire) begin
      reqreg_valid <= 1'b0;
    end
  end

  // Credit counter: one credit per accepted request, returned on response
  // send; saturates at zero so a spurious response cannot underflow it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits_used <= '0;
    end else if (netreq_fire && !netresp_fire) begin
      credits_used <= credits_used + CNT_W'(1);
    end else if (!netreq_fire && netresp_fire && (credits_used != '0)) begin
      credits_used <= credits_used - CNT_W'(1);
    end
  end

  // Response queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_count <= '0;
    end else begin
      if (memresp_fire) q_tail <= ptr_next(q_tail);
      if (netresp_fire) q_head <= ptr_next(q_head);
      if (memresp_fire && !netresp_fire)      q_count <= q_count + CNT_W'(1);
      else if (!memresp_fire && netresp_fire) q_count <= q_count - CNT_W'(1);
    end
  end

  // Response queue storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (memresp_fire) q_mem[q_tail] <= bus.memresp_msg;
  end

  // Sticky flag for requests addressed to some other endpoint.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_err_q <= 1'b0;
    end else if (netreq_fire && p_check_dest && (bus.netreq_msg_hdr.dest != src_id)) begin
      dest_err_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire
